// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline stage carrying a PC and an opaque payload between two CPU
//   stages. Ready/valid handshake on both sides, plus stall and flush. A
//   two-entry arrangement (main + skid) lets i_in_ready come straight from a
//   flop: when the downstream side stops, the one entry already in flight
//   upstream lands in the skid register instead of being lost.
//
//   Optional feature macro: PIPE_PERF_CNT_EN
//     defined   : stall and flush-drop performance counters are built
//     undefined : counter outputs are tied to zero, port list unchanged
//
// Parameters
//   PC_W     width of the PC field
//   DATA_W   width of the payload field
//   CNT_W    width of each performance counter (must be >= 2)
//
// Ports
//   i_clk              rising-edge clock
//   i_reset            synchronous active-high reset
//   i_flush            discard held entries and the current input
//   i_stall            hold the output entry, no advance
//   i_in_valid         upstream entry valid
//   o_in_ready         stage can accept (registered)
//   i_in_pc            upstream PC
//   i_in_data          upstream payload
//   o_out_valid        output entry valid
//   i_out_ready        downstream accepts
//   o_out_pc           output PC
//   o_out_data         output payload
//   o_stall_cnt        cycles with a valid output that could not leave
//   o_flush_drop_cnt   valid held entries discarded by flush
//
// state  | meaning
// -------+--------------------------------------------
// EMPTY  | no valid entry held
// FULL   | main entry valid, skid empty
// SKID   | main and skid both valid, input blocked
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_stall,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [PC_W-1:0]   i_in_pc,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [PC_W-1:0]   o_out_pc,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_flush_drop_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_in_ready;
   logic                w_in_ready_nxt;

   logic [PC_W-1:0]     r_main_pc;
   logic [DATA_W-1:0]   r_main_data;
   logic [PC_W-1:0]     r_skid_pc;
   logic [DATA_W-1:0]   r_skid_data;

   logic                w_main_valid;
   logic                w_acc;
   logic                w_adv;
   logic                w_main_ld_in;
   logic                w_main_ld_skid;
   logic                w_skid_ld_in;

   assign w_main_valid = (r_state != ST_EMPTY);
   // r_in_ready is low exactly in SKID, so no input is ever accepted there.
   assign w_acc        = i_in_valid & r_in_ready;
   // Stall overrides downstream ready.
   assign w_adv        = w_main_valid & i_out_ready & ~i_stall;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= w_in_ready_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and datapath load enables
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_main_ld_in   = 1'b0;
      w_main_ld_skid = 1'b0;
      w_skid_ld_in   = 1'b0;

      if (i_flush) begin
         // Everything held and the same-cycle input are dropped; data regs
         // keep their contents since they are don't-care while invalid.
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  w_state_nxt  = ST_FULL;
                  w_main_ld_in = 1'b1;
               end
            end
            ST_FULL: begin
               if (w_acc && w_adv) begin
                  w_state_nxt  = ST_FULL;
                  w_main_ld_in = 1'b1;
               end else if (w_acc) begin
                  w_state_nxt  = ST_SKID;
                  w_skid_ld_in = 1'b1;
               end else if (w_adv) begin
                  w_state_nxt  = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (w_adv) begin
                  w_state_nxt    = ST_FULL;
                  w_main_ld_skid = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end

      w_in_ready_nxt = (w_state_nxt != ST_SKID);
   end

   // ---------------------------------------------------------------------------
   // Entry storage
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_main_pc   <= '0;
         r_main_data <= '0;
         r_skid_pc   <= '0;
         r_skid_data <= '0;
      end else begin
         if (w_main_ld_in) begin
            r_main_pc   <= i_in_pc;
            r_main_data <= i_in_data;
         end else if (w_main_ld_skid) begin
            r_main_pc   <= r_skid_pc;
            r_main_data <= r_skid_data;
         end
         if (w_skid_ld_in) begin
            r_skid_pc   <= i_in_pc;
            r_skid_data <= i_in_data;
         end
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = w_main_valid;
   assign o_out_pc    = r_main_pc;
   assign o_out_data  = r_main_data;

   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_drop_cnt;
   logic              w_skid_valid;
   logic              w_stall_hit;
   logic [1:0]        w_drop_inc;
   logic [CNT_W:0]    w_drop_sum;

   assign w_skid_valid = (r_state == ST_SKID);
   assign w_stall_hit  = w_main_valid & (i_stall | ~i_out_ready);
   assign w_drop_inc   = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
   // One extra bit catches the carry so the add can saturate cleanly.
   assign w_drop_sum   = {1'b0, r_flush_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stall_cnt      <= '0;
         r_flush_drop_cnt <= '0;
      end else begin
         if (w_stall_hit && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
         if (i_flush) begin
            r_flush_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
         end
      end
   end

   assign o_stall_cnt      = r_stall_cnt;
   assign o_flush_drop_cnt = r_flush_drop_cnt;
`else
   assign o_stall_cnt      = '0;
   assign o_flush_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Directed bench for pipe_stage_skid: streaming, skid capture, stall
//   priority, flush in SKID and FULL, reset over flush, counter saturation.
//   Counter expectations follow whichever build PIPE_PERF_CNT_EN selects.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

   localparam int PC_W   = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk_sys;
   logic              reset;
   logic              flush;
   logic              stall;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_drop_cnt;

   int n_vec;
   int n_err;

   pipe_stage_skid #(
      .PC_W   (PC_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_dut (
      .i_clk            (clk_sys),
      .i_reset          (reset),
      .i_flush          (flush),
      .i_stall          (stall),
      .i_in_valid       (in_valid),
      .o_in_ready       (in_ready),
      .i_in_pc          (in_pc),
      .i_in_data        (in_data),
      .o_out_valid      (out_valid),
      .i_out_ready      (out_ready),
      .o_out_pc         (out_pc),
      .o_out_data       (out_data),
      .o_stall_cnt      (stall_cnt),
      .o_flush_drop_cnt (flush_drop_cnt)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      flush     = 1'b0;
      stall     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_pc     = '0;
      in_data   = '0;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [63:0] cexp(input int v);
      return PERF ? 64'(v) : 64'd0;
   endfunction

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b0;
      flush     = 1'b0;
      stall     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_pc     = '0;
      in_data   = '0;
      #2;

      // ---------------- 1. reset values and streaming ----------------
      do_reset();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_pc",    64'(out_pc),    64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_drop_cnt",  64'(flush_drop_cnt), 64'd0);

      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_pc    = 32'(4 * i);
         in_data  = 32'hD000 + 32'(i);
         step();
         chk("strm_valid", 64'(out_valid), 64'd1);
         chk("strm_pc",    64'(out_pc),    64'(4 * i));
         chk("strm_data",  64'(out_data),  64'(32'hD000 + 32'(i)));
         chk("strm_ready", 64'(in_ready),  64'd1);
      end
      in_valid = 1'b0;
      step();
      chk("strm_drain_valid", 64'(out_valid), 64'd0);
      chk("strm_stall_cnt",   64'(stall_cnt), 64'd0);

      // ---------------- 2. skid capture ----------------
      do_reset();
      in_valid  = 1'b1;
      in_pc     = 32'h100;
      in_data   = 32'hAAAA_0100;
      out_ready = 1'b0;
      step();
      chk("skid_ld_valid", 64'(out_valid), 64'd1);
      chk("skid_ld_pc",    64'(out_pc),    64'h100);
      chk("skid_ld_ready", 64'(in_ready),  64'd1);
      in_pc   = 32'h104;
      in_data = 32'hAAAA_0104;
      step();
      chk("skid_in_ready", 64'(in_ready), 64'd0);
      chk("skid_hold_pc",  64'(out_pc),   64'h100);
      in_pc   = 32'h108;          // offered while blocked, must not be taken
      in_data = 32'hAAAA_0108;
      step();
      chk("skid_block_pc",    64'(out_pc),   64'h100);
      chk("skid_block_ready", 64'(in_ready), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("skid_pop_valid", 64'(out_valid), 64'd1);
      chk("skid_pop_pc",    64'(out_pc),    64'h104);
      chk("skid_pop_data",  64'(out_data),  64'hAAAA_0104);
      chk("skid_pop_ready", 64'(in_ready),  64'd1);
      step();
      chk("skid_empty",     64'(out_valid), 64'd0);
      chk("skid_stall_cnt", 64'(stall_cnt), cexp(2));

      // ---------------- 3. stall priority ----------------
      do_reset();
      in_valid  = 1'b1;
      in_pc     = 32'h200;
      in_data   = 32'hBBBB_0200;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      stall    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stl_valid", 64'(out_valid), 64'd1);
         chk("stl_pc",    64'(out_pc),    64'h200);
      end
      chk("stl_cnt", 64'(stall_cnt), cexp(3));
      stall = 1'b0;
      step();
      chk("stl_release", 64'(out_valid), 64'd0);
      chk("stl_cnt_after", 64'(stall_cnt), cexp(3));

      // ---------------- 4. flush in SKID and in FULL ----------------
      do_reset();
      in_valid  = 1'b1;
      in_pc     = 32'h280;
      out_ready = 1'b0;
      step();
      in_pc = 32'h284;
      step();
      chk("fl_pre_ready", 64'(in_ready), 64'd0);
      flush = 1'b1;
      in_pc = 32'h300;
      step();
      chk("fl_valid",    64'(out_valid), 64'd0);
      chk("fl_ready",    64'(in_ready),  64'd1);
      chk("fl_drop_cnt", 64'(flush_drop_cnt), cexp(2));
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("fl_no_300", 64'(out_valid), 64'd0);

      in_valid = 1'b1;
      in_pc    = 32'h400;
      step();
      chk("fl2_load_pc", 64'(out_pc), 64'h400);
      flush = 1'b1;
      in_pc = 32'h404;            // accepted handshake but flushed away
      step();
      chk("fl2_valid",    64'(out_valid), 64'd0);
      chk("fl2_drop_cnt", 64'(flush_drop_cnt), cexp(3));
      flush    = 1'b0;
      in_valid = 1'b0;
      step();
      chk("fl2_no_404", 64'(out_valid), 64'd0);
      chk("fl2_stall_cnt", 64'(stall_cnt), cexp(2));

      // ---------------- 5. reset over flush while in SKID ----------------
      in_valid  = 1'b1;
      in_pc     = 32'h500;
      in_data   = 32'hCCCC_0500;
      out_ready = 1'b0;
      step();
      in_pc = 32'h504;
      step();
      chk("rf_pre_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;
      flush = 1'b1;
      in_pc = 32'h508;
      step();
      reset    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("rf_valid", 64'(out_valid), 64'd0);
      chk("rf_ready", 64'(in_ready),  64'd1);
      chk("rf_pc",    64'(out_pc),    64'd0);
      chk("rf_data",  64'(out_data),  64'd0);
      chk("rf_stall", 64'(stall_cnt), 64'd0);
      chk("rf_drop",  64'(flush_drop_cnt), 64'd0);

      // ---------------- 6. stall counter saturation ----------------
      do_reset();
      in_valid  = 1'b1;
      in_pc     = 32'h600;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      stall    = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 14) chk("sat_14", 64'(stall_cnt), cexp(14));
         if (i == 15) chk("sat_15", 64'(stall_cnt), cexp(15));
      end
      chk("sat_20",    64'(stall_cnt), cexp(15));
      chk("sat_pc",    64'(out_pc),    64'h600);
      stall = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
